// File: rtl/rx_mac_locallink_adapter.sv
// Receive MAC byte stream to LocalLink adapter: one-byte hold register so the
// last byte of a frame can be tagged EOF, plus good/bad frame statistics.
module rx_mac_locallink_adapter #(
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int MIN_FRAME_BYTES = 14
) (
  input  logic        clock,
  input  logic        RESET,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [7:0]  rx_ll_data_out,
  output logic        rx_ll_sof_out,
  output logic        rx_ll_eof_out,
  output logic        rx_ll_src_rdy_out,
  output logic        rx_ll_bad_out,
  output logic [15:0] good_frame_count,
  output logic [15:0] bad_frame_count,
  output logic [15:0] last_frame_length
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);
  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);

  typedef enum logic [1:0] {DRAIN, IDLE, FRAME} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  hold_data_reg, hold_data_next;
  logic        hold_first_reg, hold_first_next;
  logic [15:0] length_reg, length_next;
  logic        err_seen_reg, err_seen_next;
  logic [7:0]  data_reg, data_next;
  logic        sof_reg, sof_next;
  logic        eof_reg, eof_next;
  logic        src_rdy_reg, src_rdy_next;
  logic        bad_reg, bad_next;
  logic [15:0] good_count_reg, good_count_next;
  logic [15:0] bad_count_reg, bad_count_next;
  logic [15:0] last_len_reg, last_len_next;

  logic        frame_bad;
  logic [15:0] length_inc;

  // A saturated counter means the true length is unknown but certainly too long.
  assign frame_bad  = err_seen_reg || (length_reg == 16'hFFFF) ||
                      (length_reg > MAX_LEN) || (length_reg < MIN_LEN);
  assign length_inc = (length_reg == 16'hFFFF) ? 16'hFFFF : length_reg + 16'd1;

  always_ff @(posedge clock or negedge RESET) begin
    if (!RESET) begin
      state_reg      <= DRAIN;
      hold_data_reg  <= 8'h00;
      hold_first_reg <= 1'b0;
      length_reg     <= 16'd0;
      err_seen_reg   <= 1'b0;
      data_reg       <= 8'h00;
      sof_reg        <= 1'b1;
      eof_reg        <= 1'b1;
      src_rdy_reg    <= 1'b1;
      bad_reg        <= 1'b0;
      good_count_reg <= 16'd0;
      bad_count_reg  <= 16'd0;
      last_len_reg   <= 16'd0;
    end else begin
      state_reg      <= state_next;
      hold_data_reg  <= hold_data_next;
      hold_first_reg <= hold_first_next;
      length_reg     <= length_next;
      err_seen_reg   <= err_seen_next;
      data_reg       <= data_next;
      sof_reg        <= sof_next;
      eof_reg        <= eof_next;
      src_rdy_reg    <= src_rdy_next;
      bad_reg        <= bad_next;
      good_count_reg <= good_count_next;
      bad_count_reg  <= bad_count_next;
      last_len_reg   <= last_len_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hold_data_next  = hold_data_reg;
    hold_first_next = hold_first_reg;
    length_next     = length_reg;
    err_seen_next   = err_seen_reg;
    data_next       = data_reg;
    sof_next        = 1'b1;
    eof_next        = 1'b1;
    src_rdy_next    = 1'b1;
    bad_next        = 1'b0;
    good_count_next = good_count_reg;
    bad_count_next  = bad_count_reg;
    last_len_next   = last_len_reg;

    case (state_reg)
      // Waits out any frame already under way so only whole frames are delivered.
      DRAIN: begin
        if (!rx_valid) state_next = IDLE;
      end
      IDLE: begin
        if (rx_valid) begin
          hold_data_next  = rx_data;
          hold_first_next = 1'b1;
          length_next     = 16'd1;
          err_seen_next   = rx_error;
          state_next      = FRAME;
        end
      end
      FRAME: begin
        data_next    = hold_data_reg;
        src_rdy_next = 1'b0;
        sof_next     = ~hold_first_reg;
        if (rx_valid) begin
          hold_data_next  = rx_data;
          hold_first_next = 1'b0;
          length_next     = length_inc;
          err_seen_next   = err_seen_reg | rx_error;
        end else begin
          eof_next      = 1'b0;
          bad_next      = frame_bad;
          last_len_next = length_reg;
          if (frame_bad) bad_count_next  = bad_count_reg + 16'd1;
          else           good_count_next = good_count_reg + 16'd1;
          state_next    = IDLE;
        end
      end
      default: state_next = DRAIN;
    endcase
  end

  assign rx_ll_data_out    = data_reg;
  assign rx_ll_sof_out     = sof_reg;
  assign rx_ll_eof_out     = eof_reg;
  assign rx_ll_src_rdy_out = src_rdy_reg;
  assign rx_ll_bad_out     = bad_reg;
  assign good_frame_count  = good_count_reg;
  assign bad_frame_count   = bad_count_reg;
  assign last_frame_length = last_len_reg;

endmodule

// File: doc/rx_mac_locallink_adapter.md
RX_MAC_LOCALLINK_ADAPTER -- requirements
Module: rx_mac_locallink_adapter

Interface
REQ-001 SHALL have parameter MAX_FRAME_BYTES, default 1522: largest frame length, in bytes, counted as good.
REQ-002 SHALL have parameter MIN_FRAME_BYTES, default 14: smallest frame length, in bytes, counted as good.
REQ-003 SHALL have a single clock, clock, and an asynchronous active-low reset, RESET.
REQ-004 Ports:
- clock  in  1  rising-edge clock; sole clock of the block.
- RESET  in  1  asynchronous, active-low reset.
- rx_data  in  8  MAC receive byte.
- rx_valid  in  1  active high; byte valid; contiguous high for the whole frame.
- rx_error  in  1  active high; MAC error on the current byte.
- rx_ll_data_out  out  8  LocalLink data.
- rx_ll_sof_out  out  1  active low; start of frame.
- rx_ll_eof_out  out  1  active low; end of frame.
- rx_ll_src_rdy_out  out  1  active low; beat valid.
- rx_ll_bad_out  out  1  active high; frame bad, valid only on the EOF beat.
- good_frame_count  out  16  good frames completed; wraps.
- bad_frame_count  out  16  bad frames completed; wraps.
- last_frame_length  out  16  byte count of the most recently completed frame; saturating.

Function
REQ-005 All outputs SHALL be registered on the rising edge of clock.
REQ-006 SHALL implement a one-byte hold register (hold_data, hold_first) and a state machine with states IDLE, FRAME and DRAIN.
REQ-007 IDLE with rx_valid=1: SHALL load hold_data=rx_data and hold_first=1, start length=1 and go to FRAME; no beat is emitted.
REQ-008 FRAME with rx_valid=1: SHALL emit the held byte (src_rdy_out=0, sof_out=~hold_first, eof_out=1), then load the new byte with hold_first=0, increment length and stay in FRAME.
REQ-009 FRAME with rx_valid=0: SHALL emit the held byte with eof_out=0 (sof_out=~hold_first) and go to IDLE.
REQ-010 Latency SHALL be exactly 1 clock from the edge that samples a byte to that byte's beat on the outputs, for every byte including the last.
REQ-011 A 1-byte frame SHALL produce a single beat with sof_out=0 and eof_out=0.
REQ-012 SHALL emit no beat in any cycle other than those in REQ-008 and REQ-009; in those cycles src_rdy_out=1, sof_out=1, eof_out=1, bad_out=0, and data_out holds its last value.
REQ-013 A frame SHALL be marked bad if any of the following holds; bad_out SHALL be 1 on its EOF beat, else 0:
- rx_error=1 was sampled with rx_valid=1 during the frame;
- final length > MAX_FRAME_BYTES;
- final length < MIN_FRAME_BYTES.
REQ-014 The length counter SHALL be 16 bits and saturate at 16'hFFFF; a saturated length counts as > MAX_FRAME_BYTES.
REQ-015 On the EOF beat: last_frame_length SHALL take the final length, and exactly one of good_frame_count or bad_frame_count SHALL increment, modulo 2^16 (16'hFFFF+1 -> 0).
REQ-016 rx_valid low for one cycle between frames SHALL be sufficient; the next frame's first byte loads in IDLE on the cycle after the EOF beat with no byte lost.
REQ-017 Full-line-rate input with no backpressure SHALL be sustained: no stalls and no dropped bytes.
REQ-018 rx_error sampled with rx_valid=0 SHALL be ignored.

Reset
REQ-019 While RESET=0, outputs SHALL be: src_rdy_out=1, sof_out=1, eof_out=1, bad_out=0, data_out=8'h00, all counters and last_frame_length=0.
REQ-020 Reset SHALL place the state machine in DRAIN; DRAIN SHALL ignore all bytes and go to IDLE on the first cycle sampling rx_valid=0.
REQ-021 A frame in progress at reset assertion SHALL be discarded: no EOF beat and no counter update.
REQ-022 A frame already in progress at reset release SHALL be discarded in full.

Verification
REQ-023 64-byte frame 00..3F, rx_error=0 -> 64 beats, each 1 clock after its sample; sof only on 00, eof only on 3F; bad=0; good_frame_count=1; last_frame_length=64.
REQ-024 1-byte frame A5 with MIN_FRAME_BYTES=1 -> one beat A5 with sof=0, eof=0, bad=0; then a 20-byte frame with a 1-cycle gap -> both frames delivered intact; good_frame_count=2.
REQ-025 60-byte frame, rx_error=1 on byte 30 -> all 60 bytes delivered; bad=1 on the EOF beat; bad_frame_count=1, good_frame_count unchanged.
REQ-026 Frames of 1523 bytes and of 10 bytes (default parameters) -> each marked bad; bad_frame_count=2; last_frame_length=10.
REQ-027 RESET asserted on byte 20 of a 100-byte frame, released on byte 40 -> no EOF beat; remaining bytes produce no beats; the next frame is delivered normally with good_frame_count=1.
REQ-028 good_frame_count preset by 65535 good frames, plus one more good frame -> good_frame_count wraps to 0, and bad_frame_count is unchanged.
